// File: rtl/ara_pkg.sv
// Shared types and AXI constants for the Ara coherence helpers.
package ara_pkg;

   // Invalidation splitter states.
   typedef enum logic [1:0] {
      StIdle,
      StLoad,
      StBcast
   } inval_state_e;

   // AXI4 AxBURST encodings.
   localparam logic [1:0] BurstFixed = 2'b00;
   localparam logic [1:0] BurstIncr  = 2'b01;
   localparam logic [1:0] BurstWrap  = 2'b10;

endpackage

// File: rtl/fifo_v3.sv
// Synchronous FIFO (common_cells fifo_v3 interface), optional fall-through.
module fifo_v3 #(
   parameter bit          FallThrough = 1'b0,
   parameter int unsigned DATA_WIDTH  = 32,
   parameter int unsigned DEPTH       = 8,
   parameter int unsigned ADDR_DEPTH  = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  flush_i,
   input  logic                  testmode_i,
   output logic                  full_o,
   output logic                  empty_o,
   output logic [ADDR_DEPTH-1:0] usage_o,
   input  logic [DATA_WIDTH-1:0] data_i,
   input  logic                  push_i,
   output logic [DATA_WIDTH-1:0] data_o,
   input  logic                  pop_i
);

   localparam logic [ADDR_DEPTH:0]   FullCnt = (ADDR_DEPTH + 1)'(DEPTH);
   localparam logic [ADDR_DEPTH-1:0] LastIdx = ADDR_DEPTH'(DEPTH - 1);

   logic [ADDR_DEPTH-1:0] wr_ptr_q, rd_ptr_q;
   logic [ADDR_DEPTH:0]   cnt_q;
   logic [DATA_WIDTH-1:0] mem_q [DEPTH];
   logic                  cnt_zero, bypass, do_push, do_pop, store, fetch;
   logic                  unused_testmode;

   assign unused_testmode = testmode_i;
   assign cnt_zero = (cnt_q == '0);
   assign full_o   = (cnt_q == FullCnt);
   assign empty_o  = cnt_zero & ~(FallThrough & push_i);
   assign usage_o  = cnt_q[ADDR_DEPTH-1:0];
   assign data_o   = (FallThrough && cnt_zero) ? data_i : mem_q[rd_ptr_q];

   assign do_push = push_i & ~full_o;
   assign do_pop  = pop_i & ~empty_o;
   // In fall-through mode a push and pop on an empty FIFO never touch storage.
   assign bypass  = FallThrough & cnt_zero & do_push & do_pop;
   assign store   = do_push & ~bypass;
   assign fetch   = do_pop & ~bypass;

   // Pointer and occupancy bookkeeping.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else if (flush_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         if (store) wr_ptr_q <= (wr_ptr_q == LastIdx) ? '0 : wr_ptr_q + 1'b1;
         if (fetch) rd_ptr_q <= (rd_ptr_q == LastIdx) ? '0 : rd_ptr_q + 1'b1;
         if (store && !fetch)      cnt_q <= cnt_q + 1'b1;
         else if (!store && fetch) cnt_q <= cnt_q - 1'b1;
      end
   end

   // Storage array, no reset needed.
   always_ff @(posedge clk_i) begin
      if (store) mem_q[wr_ptr_q] <= data_i;
   end

endmodule

// File: rtl/ara_inval_bcast.sv
// Snoops Ara AW traffic and broadcasts per-line L1 invalidations to CVA6 harts.
module ara_inval_bcast
   import ara_pkg::*;
#(
   parameter int unsigned NrHarts     = 1,
   parameter int unsigned AddrWidth   = 64,
   parameter int unsigned L1LineWidth = 16,
   parameter int unsigned MaxTxns     = 4
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic                 en_i,
   input  logic [NrHarts-1:0]   hart_mask_i,
   input  logic                 slv_aw_valid_i,
   output logic                 slv_aw_ready_o,
   input  logic [AddrWidth-1:0] slv_aw_addr_i,
   input  logic [7:0]           slv_aw_len_i,
   input  logic [2:0]           slv_aw_size_i,
   input  logic [1:0]           slv_aw_burst_i,
   output logic                 mst_aw_valid_o,
   input  logic                 mst_aw_ready_i,
   output logic [AddrWidth-1:0] inval_addr_o,
   output logic [NrHarts-1:0]   inval_valid_o,
   input  logic [NrHarts-1:0]   inval_ready_i,
   output logic                 busy_o
);

   localparam int unsigned EntryWidth = AddrWidth + 13;
   localparam int unsigned UsageWidth = (MaxTxns > 1) ? $clog2(MaxTxns) : 1;
   localparam logic [AddrWidth-1:0] LineStep = AddrWidth'(L1LineWidth);
   localparam logic [AddrWidth-1:0] LineMask = ~(AddrWidth'(L1LineWidth - 1));
   localparam logic [AddrWidth:0]   WideOne  = (AddrWidth + 1)'(1);

   inval_state_e state_q;
   logic [AddrWidth-1:0] cur_line_q, end_line_q, last_line_q;
   logic                 last_valid_q, en_q;
   logic [NrHarts-1:0]   pending_q;

   logic                  aw_open, fifo_full, fifo_empty, fifo_push, fifo_pop;
   logic [EntryWidth-1:0] fifo_wdata, fifo_rdata;
   logic [UsageWidth-1:0] fifo_usage_unused;

   logic [AddrWidth-1:0] e_addr;
   logic [7:0]           e_len;
   logic [2:0]           e_size;
   logic [1:0]           e_burst;
   logic [15:0]          span_bytes;
   logic [AddrWidth:0]   wide_bytes, span_end_ext;
   logic [AddrWidth-1:0] span_start, start_line, end_line_n;
   logic                 en_fall, skip_load, retire, more_work;

   // AW handshake is only gated while coherence is on and the capture FIFO is full.
   assign aw_open        = ~en_i | ~fifo_full;
   assign mst_aw_valid_o = slv_aw_valid_i & aw_open;
   assign slv_aw_ready_o = mst_aw_ready_i & aw_open;
   assign fifo_push      = slv_aw_valid_i & slv_aw_ready_o & en_i;
   assign fifo_pop       = (state_q == StLoad);
   assign fifo_wdata     = {slv_aw_addr_i, slv_aw_len_i, slv_aw_size_i, slv_aw_burst_i};

   fifo_v3 #(
      .FallThrough (1'b0),
      .DATA_WIDTH  (EntryWidth),
      .DEPTH       (MaxTxns)
   ) i_aw_fifo (
      .clk_i      (clk_i),
      .rst_ni     (rst_ni),
      .flush_i    (1'b0),
      .testmode_i (1'b0),
      .full_o     (fifo_full),
      .empty_o    (fifo_empty),
      .usage_o    (fifo_usage_unused),
      .data_i     (fifo_wdata),
      .push_i     (fifo_push),
      .data_o     (fifo_rdata),
      .pop_i      (fifo_pop)
   );

   assign {e_addr, e_len, e_size, e_burst} = fifo_rdata;
   assign span_bytes = ({8'd0, e_len} + 16'd1) << e_size;
   assign wide_bytes = {{(AddrWidth - 15){1'b0}}, span_bytes};

   // Byte span of the head entry; end is computed one bit wider and truncated.
   always_comb begin
      span_start   = e_addr;
      span_end_ext = {1'b0, e_addr};
      case (e_burst)
         BurstIncr: span_end_ext = {1'b0, e_addr} + wide_bytes - WideOne;
         BurstWrap: begin
            span_start   = e_addr & ~(wide_bytes[AddrWidth-1:0] - LineStep + LineStep - 1'b1);
            span_end_ext = {1'b0, span_start} + wide_bytes - WideOne;
         end
         default: ;
      endcase
   end

   assign start_line = span_start & LineMask;
   assign end_line_n = span_end_ext[AddrWidth-1:0] & LineMask;

   assign en_fall   = en_q & ~en_i;
   assign skip_load = last_valid_q & ~en_fall & (start_line == last_line_q);
   assign retire    = (state_q == StBcast) && ((pending_q & ~inval_ready_i) == '0);
   assign more_work = ~fifo_empty | fifo_push;

   // Splitter FSM: pop an entry, then walk its lines one handshake round at a time.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q      <= StIdle;
         cur_line_q   <= '0;
         end_line_q   <= '0;
         last_line_q  <= '0;
         last_valid_q <= 1'b0;
         pending_q    <= '0;
         en_q         <= 1'b0;
      end else begin
         en_q <= en_i;
         case (state_q)
            StIdle: begin
               if (more_work) state_q <= StLoad;
            end
            StLoad: begin
               cur_line_q <= start_line;
               end_line_q <= end_line_n;
               // A line just invalidated by the previous entry is not sent again.
               pending_q  <= skip_load ? '0 : hart_mask_i;
               state_q    <= StBcast;
            end
            StBcast: begin
               pending_q <= pending_q & ~inval_ready_i;
               if (retire) begin
                  last_line_q  <= cur_line_q;
                  last_valid_q <= 1'b1;
                  if (cur_line_q == end_line_q) begin
                     state_q <= more_work ? StLoad : StIdle;
                  end else begin
                     cur_line_q <= cur_line_q + LineStep;
                     pending_q  <= hart_mask_i;
                  end
               end
            end
            default: state_q <= StIdle;
         endcase
         if (en_fall) last_valid_q <= 1'b0;
      end
   end

   assign inval_valid_o = {NrHarts{state_q == StBcast}} & pending_q;
   assign inval_addr_o  = cur_line_q;
   assign busy_o        = ~fifo_empty | (state_q != StIdle);

endmodule

// File: tb/tb_ara_inval_bcast.sv
// Directed self-checking bench for ara_inval_bcast (2 harts, 16 B lines, 4-deep FIFO).
module tb_ara_inval_bcast;
   import ara_pkg::*;

   localparam int unsigned NrHarts   = 2;
   localparam int unsigned AddrWidth = 64;

   logic                 clk = 1'b0;
   logic                 rst_ni = 1'b0;
   logic                 en_i;
   logic [NrHarts-1:0]   hart_mask_i;
   logic                 slv_aw_valid_i;
   logic                 slv_aw_ready_o;
   logic [AddrWidth-1:0] slv_aw_addr_i;
   logic [7:0]           slv_aw_len_i;
   logic [2:0]           slv_aw_size_i;
   logic [1:0]           slv_aw_burst_i;
   logic                 mst_aw_valid_o;
   logic                 mst_aw_ready_i;
   logic [AddrWidth-1:0] inval_addr_o;
   logic [NrHarts-1:0]   inval_valid_o;
   logic [NrHarts-1:0]   inval_ready_i;
   logic                 busy_o;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   ara_inval_bcast #(
      .NrHarts     (NrHarts),
      .AddrWidth   (AddrWidth),
      .L1LineWidth (16),
      .MaxTxns     (4)
   ) dut (
      .clk_i          (clk),
      .rst_ni         (rst_ni),
      .en_i           (en_i),
      .hart_mask_i    (hart_mask_i),
      .slv_aw_valid_i (slv_aw_valid_i),
      .slv_aw_ready_o (slv_aw_ready_o),
      .slv_aw_addr_i  (slv_aw_addr_i),
      .slv_aw_len_i   (slv_aw_len_i),
      .slv_aw_size_i  (slv_aw_size_i),
      .slv_aw_burst_i (slv_aw_burst_i),
      .mst_aw_valid_o (mst_aw_valid_o),
      .mst_aw_ready_i (mst_aw_ready_i),
      .inval_addr_o   (inval_addr_o),
      .inval_valid_o  (inval_valid_o),
      .inval_ready_i  (inval_ready_i),
      .busy_o         (busy_o)
   );

   // Reset with default stimulus; returns at a negedge with reset released.
   task automatic reset_dut();
      rst_ni         = 1'b0;
      en_i           = 1'b1;
      hart_mask_i    = 2'b11;
      slv_aw_valid_i = 1'b0;
      slv_aw_addr_i  = '0;
      slv_aw_len_i   = 8'd0;
      slv_aw_size_i  = 3'd0;
      slv_aw_burst_i = BurstIncr;
      mst_aw_ready_i = 1'b1;
      inval_ready_i  = 2'b11;
      repeat (2) @(negedge clk);
      rst_ni = 1'b1;
   endtask

   task automatic drive_aw(input logic [63:0] a, input logic [7:0] l, input logic [2:0] s,
                           input logic [1:0] b);
      slv_aw_valid_i = 1'b1;
      slv_aw_addr_i  = a;
      slv_aw_len_i   = l;
      slv_aw_size_i  = s;
      slv_aw_burst_i = b;
   endtask

   task automatic test_reset();
      reset_dut();
      #1;
      checks++;
      if (inval_valid_o !== 2'b00) begin
         $display("FAIL reset_valid: got %b want 00", inval_valid_o); errors++;
      end
      checks++;
      if (inval_addr_o !== 64'h0) begin
         $display("FAIL reset_addr: got %h want 0", inval_addr_o); errors++;
      end
      checks++;
      if (busy_o !== 1'b0) begin
         $display("FAIL reset_busy: got %b want 0", busy_o); errors++;
      end
      checks++;
      if ({slv_aw_ready_o, mst_aw_valid_o} !== 2'b10) begin
         $display("FAIL reset_aw: got ready/valid %b want 10", {slv_aw_ready_o, mst_aw_valid_o});
         errors++;
      end
   endtask

   // INCR 0x1008 len 3 size 3 covers 0x1008..0x1027 -> three lines, first at t+2.
   task automatic test_incr();
      logic [63:0] exp_l [3];
      exp_l = '{64'h1000, 64'h1010, 64'h1020};
      reset_dut();
      drive_aw(64'h1008, 8'd3, 3'd3, BurstIncr);
      #1;
      checks++;
      if (slv_aw_ready_o !== 1'b1) begin
         $display("FAIL incr_accept: got %b want 1", slv_aw_ready_o); errors++;
      end
      @(negedge clk);
      slv_aw_valid_i = 1'b0;
      checks++;
      if ({inval_valid_o, busy_o} !== 3'b001) begin
         $display("FAIL incr_t1: got valid/busy %b want 001", {inval_valid_o, busy_o}); errors++;
      end
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         checks++;
         if (inval_valid_o !== 2'b11 || inval_addr_o !== exp_l[i]) begin
            $display("FAIL incr_line%0d: got %b/%h want 11/%h", i, inval_valid_o, inval_addr_o,
                     exp_l[i]);
            errors++;
         end
      end
      @(negedge clk);
      checks++;
      if ({inval_valid_o, busy_o} !== 3'b000) begin
         $display("FAIL incr_done: got valid/busy %b want 000", {inval_valid_o, busy_o});
         errors++;
      end
   endtask

   task automatic test_backpressure();
      reset_dut();
      inval_ready_i = 2'b01;
      drive_aw(64'h1000, 8'd3, 3'd3, BurstIncr);
      @(negedge clk);
      slv_aw_valid_i = 1'b0;
      @(negedge clk);
      checks++;
      if (inval_valid_o !== 2'b11 || inval_addr_o !== 64'h1000) begin
         $display("FAIL bp_first: got %b/%h want 11/1000", inval_valid_o, inval_addr_o);
         errors++;
      end
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         checks++;
         if (inval_valid_o !== 2'b10 || inval_addr_o !== 64'h1000) begin
            $display("FAIL bp_hold%0d: got %b/%h want 10/1000", k, inval_valid_o, inval_addr_o);
            errors++;
         end
      end
      inval_ready_i = 2'b11;
      @(negedge clk);
      checks++;
      if (inval_valid_o !== 2'b11 || inval_addr_o !== 64'h1010) begin
         $display("FAIL bp_next: got %b/%h want 11/1010", inval_valid_o, inval_addr_o);
         errors++;
      end
      @(negedge clk);
      checks++;
      if (inval_valid_o !== 2'b00) begin
         $display("FAIL bp_done: got %b want 00", inval_valid_o); errors++;
      end
   endtask

   // First entry is popped into the stalled broadcast, then four more fill the FIFO.
   task automatic test_fifo_full();
      int c;
      reset_dut();
      inval_ready_i = 2'b00;
      for (int i = 0; i < 6; i++) begin
         if (i > 0) @(negedge clk);
         drive_aw(64'h4000 + 64'(i) * 64'h100, 8'd0, 3'd0, BurstIncr);
         #1;
         checks++;
         if (i < 5 && slv_aw_ready_o !== 1'b1) begin
            $display("FAIL full_accept%0d: got %b want 1", i, slv_aw_ready_o); errors++;
         end else if (i == 5 && {slv_aw_ready_o, mst_aw_valid_o} !== 2'b00) begin
            $display("FAIL full_block: got ready/valid %b want 00",
                     {slv_aw_ready_o, mst_aw_valid_o});
            errors++;
         end
      end
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         #1;
         checks++;
         if ({slv_aw_ready_o, mst_aw_valid_o} !== 2'b00) begin
            $display("FAIL full_hold%0d: got ready/valid %b want 00", k,
                     {slv_aw_ready_o, mst_aw_valid_o});
            errors++;
         end
      end
      checks++;
      if (inval_valid_o !== 2'b11 || inval_addr_o !== 64'h4000) begin
         $display("FAIL full_stall: got %b/%h want 11/4000", inval_valid_o, inval_addr_o);
         errors++;
      end
      inval_ready_i = 2'b11;
      @(negedge clk);
      #1;
      checks++;
      if (slv_aw_ready_o !== 1'b0) begin
         $display("FAIL full_no_bypass: got %b want 0", slv_aw_ready_o); errors++;
      end
      @(negedge clk);
      #1;
      checks++;
      if (slv_aw_ready_o !== 1'b1) begin
         $display("FAIL full_after_pop: got %b want 1", slv_aw_ready_o); errors++;
      end
      @(negedge clk);
      slv_aw_valid_i = 1'b0;
      c = 0;
      while (busy_o === 1'b1 && c < 100) begin
         @(negedge clk);
         c++;
      end
      checks++;
      if (busy_o !== 1'b0) begin
         $display("FAIL full_drain: busy still %b after %0d cycles, want 0", busy_o, c);
         errors++;
      end
   endtask

   task automatic test_coalesce();
      int  seen;
      bit  h1_seen;
      bit  bad_addr;
      seen = 0; h1_seen = 1'b0; bad_addr = 1'b0;
      reset_dut();
      hart_mask_i = 2'b01;
      drive_aw(64'h2004, 8'd0, 3'd2, BurstFixed);
      @(negedge clk);
      drive_aw(64'h200C, 8'd0, 3'd2, BurstFixed);
      for (int c = 0; c < 12; c++) begin
         if (c == 1) slv_aw_valid_i = 1'b0;
         #1;
         if (inval_valid_o !== 2'b00) begin
            seen++;
            if (inval_valid_o[1] !== 1'b0) h1_seen = 1'b1;
            if (inval_addr_o !== 64'h2000) bad_addr = 1'b1;
         end
         @(negedge clk);
      end
      checks++;
      if (seen != 1) begin
         $display("FAIL coal_count: got %0d invals want 1", seen); errors++;
      end
      checks++;
      if (h1_seen) begin
         $display("FAIL coal_mask: got hart1 valid want never"); errors++;
      end
      checks++;
      if (bad_addr) begin
         $display("FAIL coal_addr: got address other than 2000 want 2000"); errors++;
      end
      checks++;
      if (busy_o !== 1'b0) begin
         $display("FAIL coal_busy: got %b want 0", busy_o); errors++;
      end
   endtask

   task automatic test_disabled();
      reset_dut();
      en_i = 1'b0;
      drive_aw(64'h3000, 8'd0, 3'd3, BurstIncr);
      #1;
      checks++;
      if ({mst_aw_valid_o, slv_aw_ready_o} !== 2'b11) begin
         $display("FAIL dis_pass: got valid/ready %b want 11", {mst_aw_valid_o, slv_aw_ready_o});
         errors++;
      end
      mst_aw_ready_i = 1'b0;
      #1;
      checks++;
      if ({mst_aw_valid_o, slv_aw_ready_o} !== 2'b10) begin
         $display("FAIL dis_ready: got valid/ready %b want 10", {mst_aw_valid_o, slv_aw_ready_o});
         errors++;
      end
      mst_aw_ready_i = 1'b1;
      @(negedge clk);
      slv_aw_valid_i = 1'b0;
      #1;
      checks++;
      if (mst_aw_valid_o !== 1'b0) begin
         $display("FAIL dis_drop: got %b want 0", mst_aw_valid_o); errors++;
      end
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         checks++;
         if ({inval_valid_o, busy_o} !== 3'b000) begin
            $display("FAIL dis_idle%0d: got valid/busy %b want 000", c, {inval_valid_o, busy_o});
            errors++;
         end
      end
   endtask

   // WRAP 0x5018 len 7 size 2: 32-byte window aligned down to 0x5000.
   task automatic test_wrap();
      logic [63:0] exp_l [2];
      exp_l = '{64'h5000, 64'h5010};
      reset_dut();
      drive_aw(64'h5018, 8'd7, 3'd2, BurstWrap);
      @(negedge clk);
      slv_aw_valid_i = 1'b0;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         checks++;
         if (inval_valid_o !== 2'b11 || inval_addr_o !== exp_l[i]) begin
            $display("FAIL wrap_line%0d: got %b/%h want 11/%h", i, inval_valid_o, inval_addr_o,
                     exp_l[i]);
            errors++;
         end
      end
      @(negedge clk);
      checks++;
      if (inval_valid_o !== 2'b00) begin
         $display("FAIL wrap_done: got %b want 00", inval_valid_o); errors++;
      end
   endtask

   // INCR crossing the top of the address space wraps to line 0.
   task automatic test_addr_wrap();
      logic [63:0] exp_l [2];
      exp_l = '{64'hFFFF_FFFF_FFFF_FFF0, 64'h0};
      reset_dut();
      drive_aw(64'hFFFF_FFFF_FFFF_FFF8, 8'd1, 3'd3, BurstIncr);
      @(negedge clk);
      slv_aw_valid_i = 1'b0;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         checks++;
         if (inval_valid_o !== 2'b11 || inval_addr_o !== exp_l[i]) begin
            $display("FAIL awrap_line%0d: got %b/%h want 11/%h", i, inval_valid_o,
                     inval_addr_o, exp_l[i]);
            errors++;
         end
      end
      @(negedge clk);
      checks++;
      if ({inval_valid_o, busy_o} !== 3'b000) begin
         $display("FAIL awrap_done: got valid/busy %b want 000", {inval_valid_o, busy_o});
         errors++;
      end
   endtask

   task automatic test_reset_mid();
      reset_dut();
      drive_aw(64'h1008, 8'd3, 3'd3, BurstIncr);
      @(negedge clk);
      drive_aw(64'h6000, 8'd0, 3'd0, BurstFixed);
      @(negedge clk);
      slv_aw_valid_i = 1'b0;
      @(negedge clk);
      checks++;
      if (inval_valid_o !== 2'b11 || inval_addr_o !== 64'h1010) begin
         $display("FAIL rmid_pre: got %b/%h want 11/1010", inval_valid_o, inval_addr_o);
         errors++;
      end
      rst_ni = 1'b0;
      #1;
      checks++;
      if (inval_valid_o !== 2'b00 || inval_addr_o !== 64'h0 || busy_o !== 1'b0) begin
         $display("FAIL rmid_async: got %b/%h/%b want 00/0/0", inval_valid_o, inval_addr_o,
                  busy_o);
         errors++;
      end
      @(negedge clk);
      rst_ni = 1'b1;
      for (int c = 0; c < 8; c++) begin
         @(negedge clk);
         checks++;
         if ({inval_valid_o, busy_o} !== 3'b000) begin
            $display("FAIL rmid_after%0d: got valid/busy %b want 000", c,
                     {inval_valid_o, busy_o});
            errors++;
         end
      end
   endtask

   initial begin
      test_reset();
      test_incr();
      test_backpressure();
      test_fifo_full();
      test_coalesce();
      test_disabled();
      test_wrap();
      test_addr_wrap();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
